// File: rtl/gen1_2_pkg.sv
// Shared symbol constants and framer state encoding for the Gen1/2 transmit framer.
package gen1_2_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_PAD = 8'hF7;

  localparam int unsigned DLLP_LEN = 6;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    TAIL
  } state_e;

endpackage

// File: rtl/gen1_2_tx_merge.sv
// Combinational lane shifter: lays out [head, k payload bytes, optional end] from lane 0,
// pads with PAD and reports the two symbols that spill past lane W-1.
module gen1_2_tx_merge
  import gen1_2_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter int unsigned NBW = $clog2(W) + 1
) (
  input  logic [7:0]     head,
  input  logic           head_k,
  input  logic [8*W-1:0] data,
  input  logic [NBW-1:0] k,
  input  logic [7:0]     end_sym,
  input  logic           add_end,
  output logic [8*W-1:0] sym,
  output logic [W-1:0]   sym_k,
  output logic [15:0]    rem,
  output logic [1:0]     rem_k,
  output logic           overflow
);

  logic [7:0] seq_d [W+2];
  logic       seq_k [W+2];

  always_comb begin
    int j;
    int len;
    len = 1 + int'(k) + int'(add_end);
    for (int i = 0; i < int'(W) + 2; i++) begin
      j = i - 1;
      seq_d[i] = K_PAD;
      seq_k[i] = 1'b1;
      if (i == 0) begin
        seq_d[i] = head;
        seq_k[i] = head_k;
      end else if (j < int'(k)) begin
        seq_d[i] = data[8*j +: 8];
        seq_k[i] = 1'b0;
      end else if (add_end && j == int'(k)) begin
        seq_d[i] = end_sym;
        seq_k[i] = 1'b1;
      end
    end
    for (int l = 0; l < int'(W); l++) begin
      sym[8*l +: 8] = seq_d[l];
      sym_k[l]      = seq_k[l];
    end
    rem      = {seq_d[W+1], seq_d[W]};
    rem_k    = {seq_k[W+1], seq_k[W]};
    overflow = len > int'(W);
  end

endmodule

// File: rtl/gen1_2_tx_framer.sv
// Gen1/2 transmit framer: wraps link-layer beats in STP/SDP ... END/EDB with PAD fill.
// Optional GEN1_2_TX_FRAME_CHECK_EN adds a frame_err pulse output for malformed packets.
module gen1_2_tx_framer
  import gen1_2_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter int unsigned NBW = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8*W-1:0] tlp_data,
  input  logic           tlp_valid,
  output logic           tlp_ready,
  input  logic           tlp_sop,
  input  logic           tlp_eop,
  input  logic [NBW-1:0] tlp_nbytes,
  input  logic           tlp_is_dllp,
  input  logic           tlp_nullify,
  output logic [8*W-1:0] data_out,
  output logic [W-1:0]   dk_out,
  output logic [W-1:0]   valid_out
`ifdef GEN1_2_TX_FRAME_CHECK_EN
  ,
  output logic           frame_err
`endif
);

  state_e         state_q, state_d;
  logic [7:0]     carry_q, carry_d;
  logic           dllp_q, dllp_d;
  logic [15:0]    rem_q, rem_d;
  logic [1:0]     rem_k_q, rem_k_d;
  logic [8*W-1:0] data_d;
  logic [W-1:0]   dk_d, valid_d;

  logic           accept, trunc, dllp_eff;
  logic [NBW-1:0] nb_eff;
  logic [7:0]     end_sym;

  logic [7:0]     m_head, m_end;
  logic           m_head_k, m_add_end, m_overflow;
  logic [NBW-1:0] m_k;
  logic [8*W-1:0] m_sym;
  logic [W-1:0]   m_sym_k;
  logic [15:0]    m_rem;
  logic [1:0]     m_rem_k;

  // Out-of-range byte counts are framed as a full beat.
  assign nb_eff   = (tlp_nbytes == '0 || tlp_nbytes > NBW'(W)) ? NBW'(W) : tlp_nbytes;
  assign dllp_eff = (state_q == IDLE) ? tlp_is_dllp : dllp_q;
  assign end_sym  = (tlp_nullify && !dllp_eff) ? K_EDB : K_END;

  always_comb begin
    accept    = 1'b0;
    trunc     = 1'b0;
    m_head    = carry_q;
    m_head_k  = 1'b0;
    m_k       = NBW'(W);
    m_end     = end_sym;
    m_add_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tlp_valid && tlp_sop) begin
          accept   = 1'b1;
          m_head   = tlp_is_dllp ? K_SDP : K_STP;
          m_head_k = 1'b1;
        end
      end
      BODY: begin
        if (tlp_valid) begin
          if (tlp_sop) trunc = 1'b1;
          else accept = 1'b1;
        end
      end
      default: ;
    endcase
    if (trunc) begin
      m_k       = '0;
      m_end     = K_EDB;
      m_add_end = 1'b1;
    end else if (accept && tlp_eop) begin
      m_k       = nb_eff;
      m_add_end = 1'b1;
    end
  end

  gen1_2_tx_merge #(
    .W   (W),
    .NBW (NBW)
  ) u_merge (
    .head     (m_head),
    .head_k   (m_head_k),
    .data     (tlp_data),
    .k        (m_k),
    .end_sym  (m_end),
    .add_end  (m_add_end),
    .sym      (m_sym),
    .sym_k    (m_sym_k),
    .rem      (m_rem),
    .rem_k    (m_rem_k),
    .overflow (m_overflow)
  );

  always_comb begin
    state_d   = state_q;
    carry_d   = carry_q;
    dllp_d    = dllp_q;
    rem_d     = rem_q;
    rem_k_d   = rem_k_q;
    data_d    = '0;
    dk_d      = '0;
    valid_d   = '0;
    tlp_ready = (state_q != TAIL) && !trunc;
    if (trunc) begin
      data_d  = m_sym;
      dk_d    = m_sym_k;
      valid_d = '1;
      state_d = IDLE;
    end else if (accept) begin
      data_d  = m_sym;
      dk_d    = m_sym_k;
      valid_d = '1;
      if (state_q == IDLE) dllp_d = tlp_is_dllp;
      if (!tlp_eop) begin
        // A non-eop beat always spills its last byte into the next beat.
        carry_d = m_rem[7:0];
        state_d = BODY;
      end else if (m_overflow) begin
        rem_d   = m_rem;
        rem_k_d = m_rem_k;
        state_d = TAIL;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == TAIL) begin
      for (int l = 0; l < int'(W); l++) begin
        data_d[8*l +: 8] = (l < 2) ? rem_q[8*l +: 8] : K_PAD;
        dk_d[l]          = (l < 2) ? rem_k_q[l] : 1'b1;
      end
      valid_d = '1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      carry_q   <= '0;
      dllp_q    <= 1'b0;
      rem_q     <= '0;
      rem_k_q   <= '0;
      data_out  <= '0;
      dk_out    <= '0;
      valid_out <= '0;
    end else begin
      state_q   <= state_d;
      carry_q   <= carry_d;
      dllp_q    <= dllp_d;
      rem_q     <= rem_d;
      rem_k_q   <= rem_k_d;
      data_out  <= data_d;
      dk_out    <= dk_d;
      valid_out <= valid_d;
    end
  end

`ifdef GEN1_2_TX_FRAME_CHECK_EN
  logic [15:0] cnt_q, cnt_d, total;
  logic        err_d, frame_err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    total = ((state_q == IDLE) ? 16'd0 : cnt_q) + 16'(tlp_eop ? nb_eff : NBW'(W));
    if (accept) begin
      cnt_d = total;
      if (tlp_eop) begin
        if (tlp_nbytes == '0 || tlp_nbytes > NBW'(W)) err_d = 1'b1;
        if (dllp_eff ? (total != 16'(DLLP_LEN)) : (total < 16'd4)) err_d = 1'b1;
      end
    end
    if (trunc) err_d = 1'b1;
    if (state_q == IDLE && tlp_valid && !tlp_sop) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_err_q <= err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_gen1_2_tx_framer.sv
// Self-checking bench for gen1_2_tx_framer: packet-level symbol-stream model plus literal checks.
module tb_gen1_2_tx_framer;

  localparam int W   = 4;
  localparam int NBW = $clog2(W) + 1;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [8*W-1:0] d;
    logic [W-1:0]   k;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [8*W-1:0] tlp_data;
  logic           tlp_valid, tlp_ready, tlp_sop, tlp_eop, tlp_is_dllp, tlp_nullify;
  logic [NBW-1:0] tlp_nbytes;
  logic [8*W-1:0] data_out;
  logic [W-1:0]   dk_out, valid_out;
`ifdef GEN1_2_TX_FRAME_CHECK_EN
  logic           frame_err;
`endif

  gen1_2_tx_framer #(
    .W   (W),
    .NBW (NBW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tlp_data    (tlp_data),
    .tlp_valid   (tlp_valid),
    .tlp_ready   (tlp_ready),
    .tlp_sop     (tlp_sop),
    .tlp_eop     (tlp_eop),
    .tlp_nbytes  (tlp_nbytes),
    .tlp_is_dllp (tlp_is_dllp),
    .tlp_nullify (tlp_nullify),
    .data_out    (data_out),
    .dk_out      (dk_out),
    .valid_out   (valid_out)
`ifdef GEN1_2_TX_FRAME_CHECK_EN
    ,
    .frame_err   (frame_err)
`endif
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  beat_t obs_q[$];
  beat_t e;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    ready_low = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Pads the symbol stream to whole beats and queues the beats the DUT must emit.
  task automatic expect_stream(input bq_t s, input bit kf[$]);
    beat_t b;
    while (s.size() % W != 0) begin
      s.push_back(8'hF7);
      kf.push_back(1'b1);
    end
    for (int i = 0; i < s.size() / W; i++) begin
      for (int l = 0; l < W; l++) begin
        b.d[8*l +: 8] = s[i*W + l];
        b.k[l]        = kf[i*W + l];
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic send_beat(input logic [8*W-1:0] d, input bit sop, input bit eop, input int nb,
                           input bit dllp, input bit nul);
    int t;
    @(negedge clk);
    tlp_data    = d;
    tlp_valid   = 1'b1;
    tlp_sop     = sop;
    tlp_eop     = eop;
    tlp_nbytes  = NBW'(nb);
    tlp_is_dllp = dllp;
    tlp_nullify = nul;
    #1;
    t = 0;
    while (!tlp_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!tlp_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: tlp_ready got 0 for 20 cycles, expected 1");
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    tlp_valid = 1'b0;
    tlp_sop   = 1'b0;
    tlp_eop   = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_packet(input bq_t pl, input bit dllp, input bit nul, input bit trunc);
    bq_t            s;
    bit             kf[$];
    int             nbeats;
    logic [8*W-1:0] d;
    bit             last;
    s.push_back(dllp ? 8'h5C : 8'hFB);
    kf.push_back(1'b1);
    foreach (pl[i]) begin
      s.push_back(pl[i]);
      kf.push_back(1'b0);
    end
    if (trunc) s.push_back(8'hFE);
    else s.push_back((nul && !dllp) ? 8'hFE : 8'hFD);
    kf.push_back(1'b1);
    expect_stream(s, kf);
    nbeats = (pl.size() + W - 1) / W;
    for (int b = 0; b < nbeats; b++) begin
      d = '0;
      for (int l = 0; l < W; l++)
        if (b*W + l < pl.size()) d[8*l +: 8] = pl[b*W + l];
      last = (b == nbeats - 1) && !trunc;
      send_beat(d, b == 0, last, last ? pl.size() - b*W : W, dllp, nul && last);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out !== '0) begin
        obs_q.push_back({data_out, dk_out});
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %h/%h, expected no beat", data_out, dk_out);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(data_out), 64'(e.d));
          check("beat_dk", 64'(dk_out), 64'(e.k));
          check("beat_valid", 64'(valid_out), 64'({W{1'b1}}));
        end
      end else begin
        check("idle_data", 64'(data_out), 64'd0);
        check("idle_dk", 64'(dk_out), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (mon_en && !tlp_ready) ready_low++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t pl;
    rst = 1'b1;
    tlp_data = '0;
    tlp_valid = 1'b0;
    tlp_sop = 1'b0;
    tlp_eop = 1'b0;
    tlp_nbytes = '0;
    tlp_is_dllp = 1'b0;
    tlp_nullify = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_data", 64'(data_out), 64'd0);
    check("reset_dk", 64'(dk_out), 64'd0);
    check("reset_valid", 64'(valid_out), 64'd0);
    check("reset_ready", 64'(tlp_ready), 64'd1);
    rst = 1'b0;
    mon_en = 1'b1;

    // DLLP across two beats
    obs_q.delete();
    ready_low = 0;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_packet(pl, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("t1_nbeats", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() >= 2) begin
      check("t1_beat0", 64'(obs_q[0]), 64'({32'h3322115C, 4'b0001}));
      check("t1_beat1", 64'(obs_q[1]), 64'({32'hFD665544, 4'b1000}));
    end
    check("t1_ready_low", 64'(ready_low), 64'd0);

    // 12-byte TLP needing a tail beat
    obs_q.delete();
    ready_low = 0;
    pl.delete();
    for (int i = 1; i <= 12; i++) pl.push_back(8'(i));
    send_packet(pl, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("t2_nbeats", 64'(obs_q.size()), 64'd4);
    if (obs_q.size() >= 4) begin
      check("t2_beat0", 64'(obs_q[0]), 64'({32'h030201FB, 4'b0001}));
      check("t2_tail", 64'(obs_q[3]), 64'({32'hF7F7FD0C, 4'b1110}));
    end
    check("t2_ready_low", 64'(ready_low), 64'd1);

    // Nullified TLP ends in EDB
    obs_q.delete();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_packet(pl, 1'b0, 1'b1, 1'b0);
    idle(3);
    if (obs_q.size() >= 2) begin
      check("t3_beat0", 64'(obs_q[0]), 64'({32'h332211FB, 4'b0001}));
      check("t3_beat1", 64'(obs_q[1]), 64'({32'hFE665544, 4'b1000}));
    end else check("t3_nbeats", 64'(obs_q.size()), 64'd2);

    // Single-beat packet
    obs_q.delete();
    pl = '{8'hAA};
    send_packet(pl, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("t4_nbeats", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() >= 1) check("t4_beat0", 64'(obs_q[0]), 64'({32'hF7FDAAFB, 4'b1101}));

    // Reset in the middle of a packet: only the first beat ever leaves
    begin
      bq_t s;
      bit  kf[$];
      s  = '{8'hFB, 8'hB0, 8'hB1, 8'hB2};
      kf = '{1'b1, 1'b0, 1'b0, 1'b0};
      expect_stream(s, kf);
    end
    send_beat(32'hB3B2B1B0, 1'b1, 1'b0, W, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tlp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t5_data", 64'(data_out), 64'd0);
    check("t5_valid", 64'(valid_out), 64'd0);
    check("t5_ready", 64'(tlp_ready), 64'd1);
    obs_q.delete();
    pl = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_packet(pl, 1'b0, 1'b0, 1'b0);
    idle(3);
    if (obs_q.size() >= 1) check("t5_restart", 64'(obs_q[0]), 64'({32'hC2C1C0FB, 4'b0001}));
    else check("t5_nbeats", 64'(obs_q.size()), 64'd2);

    // Long idle stretch
    obs_q.delete();
    idle(10);
    check("t6_no_output", 64'(obs_q.size()), 64'd0);

    // Beat without sop in IDLE is dropped
    obs_q.delete();
    send_beat(32'h44332211, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    idle(3);
    check("drop_no_output", 64'(obs_q.size()), 64'd0);

    // sop interrupts an open packet, then a DLLP follows
    obs_q.delete();
    pl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    send_packet(pl, 1'b0, 1'b0, 1'b1);
    pl = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    send_packet(pl, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("trunc_nbeats", 64'(obs_q.size()), 64'd4);
    if (obs_q.size() >= 2) check("trunc_beat", 64'(obs_q[1]), 64'({32'hF7F7FEA3, 4'b1110}));

    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
